// File: rtl/paritysel_mux_seq_if.sv
// Bundle between the burst sequencer, its upstream/downstream and the parity-select mux.
// Carries out_err only when PARITYSEL_CHECK_EN is defined.
interface paritysel_mux_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data_a;
   logic [WIDTH-1:0] in_data_b;
   logic [3:0]       sel;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic [WIDTH-1:0] mux_data_out;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       out_sel;
   logic             out_last;
`ifdef PARITYSEL_CHECK_EN
   logic             out_err;

   modport master (
      output in_valid, in_data_a, in_data_b, mux_data_out, out_ready,
      input  in_ready, sel, data_a, data_b, out_valid, out_data, out_sel, out_last, out_err
   );
   modport slave (
      input  in_valid, in_data_a, in_data_b, mux_data_out, out_ready,
      output in_ready, sel, data_a, data_b, out_valid, out_data, out_sel, out_last, out_err
   );
`else
   modport master (
      output in_valid, in_data_a, in_data_b, mux_data_out, out_ready,
      input  in_ready, sel, data_a, data_b, out_valid, out_data, out_sel, out_last
   );
   modport slave (
      input  in_valid, in_data_a, in_data_b, mux_data_out, out_ready,
      output in_ready, sel, data_a, data_b, out_valid, out_data, out_sel, out_last
   );
`endif
endinterface

// File: rtl/paritysel_mux_seq.sv
// Burst sequencer around a parity-select mux: latches one operand pair, steps sel BURST_LEN times
// and registers each mux result on a valid/ready output. Optional PARITYSEL_CHECK_EN adds out_err.
module paritysel_mux_seq #(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 4,
   parameter int SEL_START = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   paritysel_mux_seq_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [3:0]       sel;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       out_sel;
   logic             out_valid;
   logic             out_last;
   logic [4:0]       step;
   logic             cap;
   logic             last_step;

   // A result slot is free when empty or being drained this cycle, so no bubble on consume+capture.
   assign cap       = !out_valid || bus.out_ready;
   assign last_step = (step == 5'(BURST_LEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= '0;
         data_a    <= '0;
         data_b    <= '0;
         out_data  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         step      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (out_valid && bus.out_ready) begin
                  out_valid <= 1'b0;
               end
               if (bus.in_valid) begin
                  data_a <= bus.in_data_a;
                  data_b <= bus.in_data_b;
                  sel    <= 4'(SEL_START);
                  step   <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (cap) begin
                  out_data  <= bus.mux_data_out;
                  out_sel   <= sel;
                  out_valid <= 1'b1;
                  out_last  <= last_step;
                  sel       <= sel + 4'd1;
                  step      <= step + 5'd1;
                  if (last_step) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.sel       = sel;
   assign bus.data_a    = data_a;
   assign bus.data_b    = data_b;
   assign bus.out_data  = out_data;
   assign bus.out_sel   = out_sel;
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_last;

`ifdef PARITYSEL_CHECK_EN
   logic err_q;
   logic mismatch;

   // Independent recomputation of the mux contract, captured alongside each result.
   assign mismatch = (bus.mux_data_out != ((^sel) ? data_b : data_a));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state == RUN && cap) begin
         err_q <= mismatch;
      end
   end

   assign bus.out_err = err_q & out_valid;
`endif
endmodule
